// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and alignment predicate for the data-memory arbiter.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StMerge,
    StResp
  } state_e;

  // True when the access cannot be served: bad size or address not aligned to the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = |off;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane datapath: load lane extraction with sign/zero extension, and sub-word store merge.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = old_i[{off_i, 3'b000} +: 8];
  assign half_sel = old_i[{off_i[1], 4'b0000} +: 16];

  // Select the load result and the merged store word for the requested size.
  always_comb begin
    load_o  = old_i;
    merge_o = wdata_i;
    case (size_i)
      SIZE_BYTE: begin
        load_o  = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        merge_o = old_i;
        merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SIZE_HALF: begin
        load_o  = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        merge_o = old_i;
        merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_o  = old_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-wide data memory between two requesters, with
// byte/halfword loads and read-modify-write sub-word stores.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RR_INIT = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_valid_i,
  output logic              m0_ready_o,
  input  logic              m0_we_i,
  input  logic [1:0]        m0_size_i,
  input  logic              m0_unsigned_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [31:0]       m0_wdata_i,
  output logic              m0_rsp_valid_o,
  output logic [31:0]       m0_rsp_data_o,
  output logic              m0_rsp_err_o,
  input  logic              m1_valid_i,
  output logic              m1_ready_o,
  input  logic              m1_we_i,
  input  logic [1:0]        m1_size_i,
  input  logic              m1_unsigned_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [31:0]       m1_wdata_i,
  output logic              m1_rsp_valid_o,
  output logic [31:0]       m1_rsp_data_o,
  output logic              m1_rsp_err_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic [31:0]       mem_wd_o,
  output logic              mem_we_o,
  input  logic [31:0]       mem_rd_i
);

  state_e            state_q;
  logic              prio_q;
  logic              grant_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] mem_adr_q;
  logic [31:0]       mem_wd_q;
  logic              mem_we_q;
  logic [1:0]        rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;

  logic              win_m0, win_m1, idle_ok, accept;
  logic              in_we, in_uns, in_err;
  logic [1:0]        in_size;
  logic [ADDR_W-1:0] in_adr;
  logic [31:0]       in_wdata;
  logic [31:0]       load_data, merge_data;

  // Priority master wins a tie; a lone requester wins regardless of priority.
  assign win_m0     = m0_valid_i & (~prio_q | ~m1_valid_i);
  assign win_m1     = m1_valid_i & (prio_q | ~m0_valid_i);
  assign idle_ok    = (state_q == StIdle) & ~rst_i;
  assign m0_ready_o = idle_ok & win_m0;
  assign m1_ready_o = idle_ok & win_m1;
  assign accept     = m0_ready_o | m1_ready_o;

  assign in_we    = m1_ready_o ? m1_we_i       : m0_we_i;
  assign in_size  = m1_ready_o ? m1_size_i     : m0_size_i;
  assign in_uns   = m1_ready_o ? m1_unsigned_i : m0_unsigned_i;
  assign in_adr   = m1_ready_o ? m1_adr_i      : m0_adr_i;
  assign in_wdata = m1_ready_o ? m1_wdata_i    : m0_wdata_i;
  assign in_err   = misaligned(in_size, in_adr[1:0]);

  dmem_lane_unit u_lane (
    .size_i     (size_q),
    .off_i      (off_q),
    .unsigned_i (uns_q),
    .old_i      (mem_rd_i),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  // Arbiter FSM with registered memory and response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      prio_q      <= 1'(RR_INIT);
      grant_q     <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= SIZE_BYTE;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      mem_adr_q   <= '0;
      mem_wd_q    <= '0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            grant_q <= m1_ready_o;
            we_q    <= in_we;
            size_q  <= in_size;
            uns_q   <= in_uns;
            off_q   <= in_adr[1:0];
            wdata_q <= in_wdata;
            err_q   <= in_err;
            // Address goes out on the accept edge so mem_rd is valid throughout ACCESS.
            if (!in_err) mem_adr_q <= {in_adr[ADDR_W-1:2], 2'b00};
            if (!in_err && in_we && in_size == SIZE_WORD) begin
              mem_we_q <= 1'b1;
              mem_wd_q <= in_wdata;
            end
            state_q <= StAccess;
          end
        end
        StAccess: begin
          mem_we_q <= 1'b0;
          if (err_q) begin
            rsp_err_q            <= 1'b1;
            rsp_data_q           <= '0;
            rsp_valid_q[grant_q] <= 1'b1;
            state_q              <= StResp;
          end else if (!we_q) begin
            rsp_data_q           <= load_data;
            rsp_valid_q[grant_q] <= 1'b1;
            state_q              <= StResp;
          end else if (size_q == SIZE_WORD) begin
            rsp_data_q           <= '0;
            rsp_valid_q[grant_q] <= 1'b1;
            state_q              <= StResp;
          end else begin
            mem_wd_q <= merge_data;
            mem_we_q <= 1'b1;
            state_q  <= StMerge;
          end
        end
        StMerge: begin
          mem_we_q             <= 1'b0;
          rsp_data_q           <= '0;
          rsp_valid_q[grant_q] <= 1'b1;
          state_q              <= StResp;
        end
        StResp: begin
          rsp_valid_q <= 2'b00;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= '0;
          prio_q      <= ~grant_q;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign mem_adr_o = mem_adr_q;
  assign mem_wd_o  = mem_wd_q;
  // Reset must suppress a write already registered for the current cycle.
  assign mem_we_o  = mem_we_q & ~rst_i;

  assign m0_rsp_valid_o = rsp_valid_q[0];
  assign m1_rsp_valid_o = rsp_valid_q[1];
  assign m0_rsp_data_o  = rsp_valid_q[0] ? rsp_data_q : 32'h0;
  assign m1_rsp_data_o  = rsp_valid_q[1] ? rsp_data_q : 32'h0;
  assign m0_rsp_err_o   = rsp_valid_q[0] & rsp_err_q;
  assign m1_rsp_err_o   = rsp_valid_q[1] & rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: byte-array memory model plus a response scoreboard.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_valid, m0_ready, m0_we, m0_uns, m0_rsp_valid, m0_rsp_err;
  logic        m1_valid, m1_ready, m1_we, m1_uns, m1_rsp_valid, m1_rsp_err;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_adr, m1_adr, m0_wdata, m1_wdata, m0_rsp_data, m1_rsp_data;
  logic [31:0] mem_adr, mem_wd, mem_rd;
  logic        mem_we;

  logic [7:0]  mem [0:65535];
  logic [15:0] ma;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          we_cnt = 0;
  bit          we_seen = 1'b0;

  typedef struct {
    int          m;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.ADDR_W(32), .RR_INIT(0)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_valid_i(m0_valid), .m0_ready_o(m0_ready), .m0_we_i(m0_we), .m0_size_i(m0_size),
    .m0_unsigned_i(m0_uns), .m0_adr_i(m0_adr), .m0_wdata_i(m0_wdata),
    .m0_rsp_valid_o(m0_rsp_valid), .m0_rsp_data_o(m0_rsp_data), .m0_rsp_err_o(m0_rsp_err),
    .m1_valid_i(m1_valid), .m1_ready_o(m1_ready), .m1_we_i(m1_we), .m1_size_i(m1_size),
    .m1_unsigned_i(m1_uns), .m1_adr_i(m1_adr), .m1_wdata_i(m1_wdata),
    .m1_rsp_valid_o(m1_rsp_valid), .m1_rsp_data_o(m1_rsp_data), .m1_rsp_err_o(m1_rsp_err),
    .mem_adr_o(mem_adr), .mem_wd_o(mem_wd), .mem_we_o(mem_we), .mem_rd_i(mem_rd)
  );

  // Little-endian byte memory: combinational read, posedge write.
  assign ma     = mem_adr[15:0];
  assign mem_rd = {mem[ma + 16'd3], mem[ma + 16'd2], mem[ma + 16'd1], mem[ma]};

  always @(posedge clk) begin
    if (mem_we) begin
      mem[ma]         = mem_wd[7:0];
      mem[ma + 16'd1] = mem_wd[15:8];
      mem[ma + 16'd2] = mem_wd[23:16];
      mem[ma + 16'd3] = mem_wd[31:24];
    end
  end

  // A transaction may write memory in at most one cycle.
  always @(posedge clk) begin
    if (rst || (m0_valid && m0_ready) || (m1_valid && m1_ready)) begin
      we_seen = 1'b0;
    end else if (mem_we) begin
      n_tests++;
      assert (!we_seen) else begin
        n_fail++;
        $error("FAIL we_once: observed second mem_we pulse at cycle %0d, required at most one", cyc);
      end
      we_seen = 1'b1;
      we_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rd_word(input int a);
    return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
  endfunction

  task automatic wr_word(input int a, input logic [31:0] d);
    {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]} = d;
  endtask

  task automatic set_req(input int m, input logic v, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] adr, input logic [31:0] wd);
    if (m == 0) begin
      m0_valid = v; m0_we = we; m0_size = sz; m0_uns = uns; m0_adr = adr; m0_wdata = wd;
    end else begin
      m1_valid = v; m1_we = we; m1_size = sz; m1_uns = uns; m1_adr = adr; m1_wdata = wd;
    end
  endtask

  // Waits for master m to be accepted; reports the other master's ready in the same cycle.
  task automatic wait_accept(input int m, output int acc, output logic other_rdy);
    acc = -1;
    other_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ready : m1_ready) begin
        acc = cyc;
        other_rdy = (m == 0) ? m1_ready : m0_ready;
        @(posedge clk);
        #1;
        if (m == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
        break;
      end
    end
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input int m, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] adr, input logic [31:0] wd,
                       input logic [31:0] edata, input logic eerr, input int lat);
    int   acc;
    logic orr;
    exp_t e;
    set_req(m, 1'b1, we, sz, uns, adr, wd);
    wait_accept(m, acc, orr);
    e.m = m; e.data = edata; e.err = eerr; e.lat = lat; e.acc = acc;
    exp_q.push_back(e);
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    bit   seen;
    e = exp_q.pop_front();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((e.m == 0) ? m0_rsp_valid : m1_rsp_valid) begin
        seen = 1'b1;
        chk({tag, "_data"}, (e.m == 0) ? m0_rsp_data : m1_rsp_data, e.data);
        chk({tag, "_err"}, {31'd0, (e.m == 0) ? m0_rsp_err : m1_rsp_err}, {31'd0, e.err});
        chk({tag, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
        chk({tag, "_other"}, {31'd0, (e.m == 0) ? m1_rsp_valid : m0_rsp_valid}, 32'd0);
        break;
      end
    end
    if (!seen) chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int   acc;
    logic orr;
    int   we0;
    bit   stray;

    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    wr_word(1000, 32'h8899AABB);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    chk("rst_rsp", {28'd0, m1_rsp_valid, m0_rsp_valid, m1_rsp_err, m0_rsp_err}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_adr", mem_adr, 32'd0);
    chk("rst_wd", mem_wd, 32'd0);
    chk("rst_rdata", m0_rsp_data | m1_rsp_data, 32'd0);

    // 1: word load
    issue(0, 1'b0, 2'b10, 1'b0, 32'd1000, 32'd0, 32'h8899AABB, 1'b0, 2);
    check_rsp("ld_word");

    // 2: byte store merge, then signed/unsigned byte loads
    wr_word(1000, 32'h11223344);
    issue(1, 1'b1, 2'b00, 1'b0, 32'd1002, 32'h0000005A, 32'h0, 1'b0, 3);
    check_rsp("st_byte");
    chk("st_byte_mem", rd_word(1000), 32'h115A3344);
    wr_word(1000, 32'h8899AABB);
    issue(1, 1'b0, 2'b00, 1'b0, 32'd1003, 32'd0, 32'hFFFFFF88, 1'b0, 2);
    check_rsp("ld_byte_s");
    issue(1, 1'b0, 2'b00, 1'b1, 32'd1003, 32'd0, 32'h00000088, 1'b0, 2);
    check_rsp("ld_byte_u");
    issue(0, 1'b0, 2'b01, 1'b0, 32'd1000, 32'd0, 32'hFFFFAABB, 1'b0, 2);
    check_rsp("ld_half_s");

    // 3: simultaneous requests alternate after reset
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1000, 32'd0);
    set_req(1, 1'b1, 1'b0, 2'b00, 1'b1, 32'd1000, 32'd0);
    wait_accept(0, acc, orr);
    chk("rr1_loser_rdy", {31'd0, orr}, 32'd0);
    exp_q.push_back('{m: 0, data: 32'h8899AABB, err: 1'b0, lat: 2, acc: acc});
    check_rsp("rr1");
    set_req(0, 1'b1, 1'b0, 2'b01, 1'b1, 32'd1002, 32'd0);
    wait_accept(1, acc, orr);
    chk("rr2_loser_rdy", {31'd0, orr}, 32'd0);
    exp_q.push_back('{m: 1, data: 32'h000000BB, err: 1'b0, lat: 2, acc: acc});
    check_rsp("rr2");
    set_req(1, 1'b1, 1'b0, 2'b00, 1'b1, 32'd1001, 32'd0);
    wait_accept(0, acc, orr);
    chk("rr3_loser_rdy", {31'd0, orr}, 32'd0);
    exp_q.push_back('{m: 0, data: 32'h00008899, err: 1'b0, lat: 2, acc: acc});
    check_rsp("rr3");
    wait_accept(1, acc, orr);
    exp_q.push_back('{m: 1, data: 32'h000000AA, err: 1'b0, lat: 2, acc: acc});
    check_rsp("rr4");

    // 4: misaligned half and illegal size
    we0 = we_cnt;
    issue(0, 1'b0, 2'b01, 1'b0, 32'd1001, 32'd0, 32'h0, 1'b1, 2);
    check_rsp("err_half");
    issue(0, 1'b1, 2'b11, 1'b0, 32'd1000, 32'hCAFEF00D, 32'h0, 1'b1, 2);
    check_rsp("err_ill");
    issue(1, 1'b1, 2'b10, 1'b0, 32'd1002, 32'hCAFEF00D, 32'h0, 1'b1, 2);
    check_rsp("err_word");
    chk("err_no_we", 32'(we_cnt - we0), 32'd0);
    chk("err_mem", rd_word(1000), 32'h8899AABB);

    // 5: reset during MERGE of a half store
    wr_word(1000, 32'h11223344);
    we0 = we_cnt;
    set_req(0, 1'b1, 1'b1, 2'b01, 1'b0, 32'd1002, 32'h0000BEEF);
    wait_accept(0, acc, orr);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem", rd_word(1000), 32'h11223344);
    chk("abort_no_we", 32'(we_cnt - we0), 32'd0);
    chk("abort_outs", {29'd0, mem_we, m0_rsp_valid, m0_ready}, 32'd0);
    chk("abort_adr", mem_adr, 32'd0);
    chk("abort_wd", mem_wd, 32'd0);
    #1 rst = 1'b0;
    stray = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (m0_rsp_valid || m1_rsp_valid || mem_we) stray = 1'b1;
    end
    chk("abort_no_rsp", {31'd0, stray}, 32'd0);

    // 6: half and word stores
    issue(0, 1'b1, 2'b01, 1'b0, 32'd1002, 32'h1234BEEF, 32'h0, 1'b0, 3);
    check_rsp("st_half");
    chk("st_half_mem", rd_word(1000), 32'hBEEF3344);
    issue(1, 1'b1, 2'b10, 1'b0, 32'd1000, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check_rsp("st_word");
    chk("st_word_mem", rd_word(1000), 32'hDEADBEEF);
    chk("st_word_adr", mem_adr, 32'd1000);
    issue(0, 1'b1, 2'b00, 1'b0, 32'd1001, 32'h00000077, 32'h0, 1'b0, 3);
    check_rsp("st_byte1");
    chk("st_byte1_mem", rd_word(1000), 32'hDEAD77EF);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
